// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter states and frame sizing.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Total bit periods in one frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and same-cycle push/pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_c,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       not_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_d;

    assign head_c = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            not_full <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count    <= count_d;
            not_full <= (count_d != CW'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an input FIFO; frames go out back-to-back while data
// is queued and CTS is asserted at frame start.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 1,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY         = 0,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_BITS-1:0]            in_data,
    input  logic                            cts_n,
    output logic                            serial_tx,
    output logic                            active,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    if (CLOCKS_PER_BIT < 1) begin : g_bad_cpb
        $error("CLOCKS_PER_BIT must be >= 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("DATA_BITS must be in 5..9");
    end
    if (PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_d, active_d;
    logic                 pop, push, tick, can_start, start_frame;
    logic [DATA_BITS-1:0] head_c;

    assign push      = in_valid && in_ready;
    assign tick      = (clk_cnt_q == CNT_W'(CLOCKS_PER_BIT - 1));
    assign can_start = (fifo_count != '0) && !cts_n;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head_c    (head_c),
        .count     (fifo_count),
        .not_full  (in_ready)
    );

    // Next-state and next-line logic; serial_tx is registered from tx_d.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = tick ? '0 : clk_cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = serial_tx;
        active_d    = active;
        pop         = 1'b0;
        start_frame = 1'b0;
        case (state_q)
            TX_IDLE: begin
                clk_cnt_d = '0;
                if (can_start) start_frame = 1'b1;
            end
            TX_START: begin
                if (tick) begin
                    state_d   = TX_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = TX_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = TX_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    state_d   = TX_STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        if (can_start) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d  = TX_IDLE;
                            active_d = 1'b0;
                            tx_d     = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
        // Frame start is shared by the idle path and the back-to-back path.
        if (start_frame) begin
            pop       = 1'b1;
            shift_d   = head_c;
            par_d     = (^head_c) ^ (PARITY == PARITY_ODD);
            state_d   = TX_START;
            tx_d      = 1'b0;
            active_d  = 1'b1;
            clk_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= TX_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            serial_tx <= 1'b1;
            active    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            serial_tx <= tx_d;
            active    <= active_d;
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO, valid/ready handshake, configurable frame format (data bits, parity, stop bits) and CTS flow control. It replaces the single-byte, pulse-triggered transmitter. Upstream logic pushes words without tracking frame timing. Frames go out back-to-back while data is queued and CTS permits.

Parameters:
CLOCKS_PER_BIT, 1, clock cycles per UART bit (CLOCK_SPEED/BAUD_RATE, rounded); legal >= 1
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2

Ports:
clock  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  FIFO can accept a word this cycle
in_data  input  DATA_BITS  word to transmit, LSB sent first
cts_n  input  1  clear-to-send, active-low; high blocks new frames
serial_tx  output  1  UART line, idle high
active  output  1  a frame is in progress (START through last STOP)
fifo_count  output  $clog2(FIFO_DEPTH+1)  words currently queued

Behaviour:
- Reset (reset_n low, asynchronous): serial_tx=1, active=0, FIFO emptied, fifo_count=0, state IDLE, counters 0. in_ready=1 once reset_n is high.
- Reset mid-frame aborts the frame. The line returns high immediately, without waiting for a clock edge.
- Handshake: a transfer occurs on the rising edge where in_valid && in_ready. in_ready = (fifo_count != FIFO_DEPTH) and is decoded from registered state only, with no combinational path from in_valid.
- Push and pop on the same edge are legal. fifo_count is then unchanged. A push while full is impossible by construction.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START.
- IDLE: serial_tx=1, active=0. On an edge with fifo_count != 0 and cts_n == 0: pop the head word into the shift register, compute parity, go to START with active=1, serial_tx=0.
- Latency: a word accepted into an empty FIFO while idle, with cts_n low, at edge N is popped at edge N+1. serial_tx falls at edge N+1.
- Each bit holds serial_tx constant for exactly CLOCKS_PER_BIT cycles. The clock counter is at least 1 bit wide, so CLOCKS_PER_BIT=1 is legal.
- DATA: DATA_BITS bits, LSB first.
- PARITY: present only if PARITY != 0. Even parity bit = XOR of the data bits; odd parity bit = its inverse.
- STOP: serial_tx=1 for STOP_BITS*CLOCKS_PER_BIT cycles.
- Frame end, at the final edge of the last stop bit:
  - If fifo_count != 0 and cts_n == 0: pop and go directly to START. No idle cycle between frames; active stays 1.
  - Otherwise: go to IDLE, active=0.
- cts_n is sampled only at frame start. Deasserting it mid-frame never truncates or stretches the current frame.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLOCKS_PER_BIT cycles.
- in_data bits above DATA_BITS do not exist. Width comes only from the parameter.
- Illegal parameter values trigger an elaboration-time error.

Decomposition:
- Package uart_pkg holds:
  - parity constants PARITY_NONE/ODD/EVEN
  - tx state enum (IDLE, START, DATA, PARITY, STOP)
  - a function returning frame bit count from parameters
- One natural sub-module: sync_fifo (parametrised width/depth, registered count, same-cycle push/pop). It is reused later by the receiver.
- The framer FSM stays in uart_tx_fifo.

Test Plan:
- Single frame, no parity: CLOCKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1. Push 0x55 while idle, cts_n=0 -> serial_tx 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. active high for exactly 40 cycles, then serial_tx=1, active=0.
- Parity:
  - PARITY=2, push 0x07 -> parity bit 1.
  - PARITY=1, push 0x00 -> parity bit 1.
  - In both cases the frame is 11 bits and the stop bit is high.
- FIFO full / CTS block: FIFO_DEPTH=4, cts_n=1, push 0x01..0x04 -> fifo_count=4, in_ready=0, serial_tx stays 1. A 5th word held on in_valid is not accepted.
- CTS release after the full case: drop cts_n -> frames 0x01..0x04 go out back-to-back, with zero idle cycles between stop and start. The held 5th word is accepted the edge after the first pop.
- Two-stop-bit, 7-bit config: DATA_BITS=7, STOP_BITS=2, CLOCKS_PER_BIT=1 -> frame 0x41 = 0,1,0,0,0,0,0,1,1,1. Exactly 10 cycles.
- Reset and mid-frame CTS:
  - Assert reset_n=0 mid-data-bit -> serial_tx=1 without a clock edge, fifo_count=0, active=0.
  - Toggling cts_n mid-frame -> frame unchanged.
